// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V control path: FSM states,
// major opcodes and the datapath mux/ALU select encodings.
`timescale 1ns/1ps
package riscv_pkg;

  // Main control FSM states
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  // Major opcodes (instruction bits [6:0])
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // ALU operation class handed to alu_dec
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU source A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU source B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/main_fsm.sv
// Main control FSM of the multicycle RISC-V core. Moore-style outputs decoded
// from the state register; the only input-qualified outputs are irwrite and
// pcupdate in FETCH (gated by the memory access completing) and illegal_op in
// DECODE. state_dbg_o exposes the current state for checkers.
`timescale 1ns/1ps
module main_fsm
  import riscv_pkg::*;
#(
  parameter int unsigned WAIT_MEM = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       pcupdate,
  output logic       branch,
  output logic       regwrite,
  output logic       memwrite,
  output logic       irwrite,
  output logic       adrsrc,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       illegal_op,
  output logic [3:0] state_dbg_o
);

  state_e state_q, state_d;
  logic   mem_done;

  // A memory state may leave when the access completes, or always when the
  // memory is treated as single-cycle.
  assign mem_done    = (WAIT_MEM == 0) ? 1'b1 : mem_ready;
  assign state_dbg_o = state_q;

  // State register; reset lands in FETCH immediately, independent of clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state selection; unknown encodings fall back to FETCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_done) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_done) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_done) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode; anything not driven by a state stays 0.
  always_comb begin
    pcupdate   = 1'b0;
    branch     = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    adrsrc     = 1'b0;
    resultsrc  = RES_ALUOUT;
    alusrca    = SRCA_PC;
    alusrcb    = SRCB_RS2;
    aluop      = ALUOP_ADD;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURES;
        irwrite   = mem_done;
        pcupdate  = mem_done;
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ: illegal_op = 1'b0;
          default: illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
      end
      S_MEMWB: begin
        resultsrc = RES_DATA;
        regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECR: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
      end
      S_JAL: begin
        alusrca  = SRCA_OLDPC;
        alusrcb  = SRCB_FOUR;
        pcupdate = 1'b1;
      end
      S_BEQ: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: two instances (memory wait enabled / disabled) driven
// in lock-step by a step-list reference model, a per-opcode table of
// latency and write counts, and hand sequences for reset and stall corners.
`timescale 1ns/1ps
module tb_main_fsm;
  import riscv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       mem_ready;
  logic [6:0] op_w1, op_w0;

  logic pcupdate_w1, branch_w1, regwrite_w1, memwrite_w1, irwrite_w1, adrsrc_w1, illegal_w1;
  logic [1:0] resultsrc_w1, alusrca_w1, alusrcb_w1, aluop_w1;
  logic [3:0] state_w1;
  logic pcupdate_w0, branch_w0, regwrite_w0, memwrite_w0, irwrite_w0, adrsrc_w0, illegal_w0;
  logic [1:0] resultsrc_w0, alusrca_w0, alusrcb_w0, aluop_w0;
  logic [3:0] state_w0;

  main_fsm #(.WAIT_MEM(1)) u_w1 (
    .clk(clk), .reset(reset), .op(op_w1), .mem_ready(mem_ready),
    .pcupdate(pcupdate_w1), .branch(branch_w1), .regwrite(regwrite_w1),
    .memwrite(memwrite_w1), .irwrite(irwrite_w1), .adrsrc(adrsrc_w1),
    .resultsrc(resultsrc_w1), .alusrca(alusrca_w1), .alusrcb(alusrcb_w1),
    .aluop(aluop_w1), .illegal_op(illegal_w1), .state_dbg_o(state_w1)
  );

  main_fsm #(.WAIT_MEM(0)) u_w0 (
    .clk(clk), .reset(reset), .op(op_w0), .mem_ready(mem_ready),
    .pcupdate(pcupdate_w0), .branch(branch_w0), .regwrite(regwrite_w0),
    .memwrite(memwrite_w0), .irwrite(irwrite_w0), .adrsrc(adrsrc_w0),
    .resultsrc(resultsrc_w0), .alusrca(alusrca_w0), .alusrcb(alusrcb_w0),
    .aluop(aluop_w0), .illegal_op(illegal_w0), .state_dbg_o(state_w0)
  );

  // {pcupdate, branch, regwrite, memwrite, irwrite, adrsrc, resultsrc, alusrca, alusrcb, aluop, illegal_op}
  logic [14:0] act_w1, act_w0;
  assign act_w1 = {pcupdate_w1, branch_w1, regwrite_w1, memwrite_w1, irwrite_w1, adrsrc_w1,
                   resultsrc_w1, alusrca_w1, alusrcb_w1, aluop_w1, illegal_w1};
  assign act_w0 = {pcupdate_w0, branch_w0, regwrite_w0, memwrite_w0, irwrite_w0, adrsrc_w0,
                   resultsrc_w0, alusrca_w0, alusrcb_w0, aluop_w0, illegal_w0};

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  typedef enum logic [3:0] {T_F, T_D, T_MA, T_MR, T_MWB, T_MW, T_XR, T_XI, T_AW, T_J, T_B} step_e;
  step_e exp_q1[$];
  step_e exp_q0[$];

  // 0 lw, 1 sw, 2 R, 3 I, 4 jal, 5 beq, 6 unsupported
  function automatic int op_kind(input logic [6:0] o);
    case (o)
      7'b0000011: return 0;
      7'b0100011: return 1;
      7'b0110011: return 2;
      7'b0010011: return 3;
      7'b1101111: return 4;
      7'b1100011: return 5;
      default:    return 6;
    endcase
  endfunction

  function automatic int n_steps(input logic [6:0] o);
    case (op_kind(o))
      0: return 5;
      5: return 3;
      6: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic step_e nth_step(input logic [6:0] o, input int i);
    if (i == 0) return T_F;
    if (i == 1) return T_D;
    case (op_kind(o))
      0: return (i == 2) ? T_MA : (i == 3) ? T_MR : T_MWB;
      1: return (i == 2) ? T_MA : T_MW;
      2: return (i == 2) ? T_XR : T_AW;
      3: return (i == 2) ? T_XI : T_AW;
      4: return (i == 2) ? T_J  : T_AW;
      default: return T_B;
    endcase
  endfunction

  function automatic logic [3:0] step_state(input step_e s);
    case (s)
      T_F:   return S_FETCH;
      T_D:   return S_DECODE;
      T_MA:  return S_MEMADR;
      T_MR:  return S_MEMREAD;
      T_MWB: return S_MEMWB;
      T_MW:  return S_MEMWRITE;
      T_XR:  return S_EXECR;
      T_XI:  return S_EXECI;
      T_AW:  return S_ALUWB;
      T_J:   return S_JAL;
      default: return S_BEQ;
    endcase
  endfunction

  function automatic bit is_mem(input step_e s);
    return (s == T_F) || (s == T_MR) || (s == T_MW);
  endfunction

  function automatic logic [14:0] exp_out(input step_e s, input logic rdy, input bit wm,
                                          input logic [6:0] o);
    logic pc, br, rw, mw, ir, ad, il;
    logic [1:0] rs, sa, sb, ao;
    {pc, br, rw, mw, ir, ad, il} = '0;
    {rs, sa, sb, ao} = '0;
    case (s)
      T_F:   begin sb = 2'b10; rs = 2'b10; ir = rdy | ~wm; pc = rdy | ~wm; end
      T_D:   begin sa = 2'b01; sb = 2'b01; il = (op_kind(o) == 6); end
      T_MA:  begin sa = 2'b10; sb = 2'b01; end
      T_MR:  begin ad = 1'b1; end
      T_MWB: begin rs = 2'b01; rw = 1'b1; end
      T_MW:  begin ad = 1'b1; mw = 1'b1; end
      T_XR:  begin sa = 2'b10; ao = 2'b10; end
      T_XI:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
      T_AW:  begin rw = 1'b1; end
      T_J:   begin sa = 2'b01; sb = 2'b10; pc = 1'b1; end
      default: begin sa = 2'b10; ao = 2'b01; br = 1'b1; end
    endcase
    return {pc, br, rw, mw, ir, ad, rs, sa, sb, ao, il};
  endfunction

  function automatic logic [6:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 7'b0000011;
      1: return 7'b0100011;
      2: return 7'b0110011;
      3: return 7'b0010011;
      4: return 7'b1101111;
      5: return 7'b1100011;
      default: return 7'($urandom_range(0, 127));
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [6:0] op;
    int lat;
    int n_rw;
    int n_mw;
    int n_ill;
  } vec_t;
  vec_t vecs[8];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [6:0] rop1, rop0;
    step_e s1, s0;
    int cyc, rw, mw, il;

    vecs[0] = '{7'b0000011, 5, 1, 0, 0};
    vecs[1] = '{7'b0100011, 4, 0, 1, 0};
    vecs[2] = '{7'b0110011, 4, 1, 0, 0};
    vecs[3] = '{7'b0010011, 4, 1, 0, 0};
    vecs[4] = '{7'b1101111, 4, 1, 0, 0};
    vecs[5] = '{7'b1100011, 3, 0, 0, 0};
    vecs[6] = '{7'b1111111, 2, 0, 0, 1};
    vecs[7] = '{7'b0000000, 2, 0, 0, 1};

    // Reset state
    reset = 1'b1; mem_ready = 1'b0; op_w1 = '0; op_w0 = '0;
    #1;
    check("reset_state_w1", state_w1, S_FETCH);
    check("reset_state_w0", state_w0, S_FETCH);
    check("reset_out_w1", act_w1, exp_out(T_F, 1'b0, 1'b1, 7'd0));
    check("reset_out_w0", act_w0, exp_out(T_F, 1'b0, 1'b0, 7'd0));

    // Per-opcode latency and write counts, memory wait disabled, mem_ready low
    foreach (vecs[k]) begin
      do_reset();
      cyc = 0; rw = 0; mw = 0; il = 0;
      do begin
        @(negedge clk);
        op_w0 = vecs[k].op; mem_ready = 1'b0;
        #1;
        rw += int'(regwrite_w0); mw += int'(memwrite_w0); il += int'(illegal_w0);
        cyc++;
        @(posedge clk); #1;
      end while (state_w0 != S_FETCH && cyc < 20);
      check($sformatf("lat_%b", vecs[k].op), cyc, vecs[k].lat);
      check($sformatf("regwrite_cnt_%b", vecs[k].op), rw, vecs[k].n_rw);
      check($sformatf("memwrite_cnt_%b", vecs[k].op), mw, vecs[k].n_mw);
      check($sformatf("illegal_cnt_%b", vecs[k].op), il, vecs[k].n_ill);
    end

    // lw with no memory wait: state walk, regwrite only in cycle 5 with resultsrc=01
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      op_w0 = 7'b0000011; mem_ready = 1'b0;
      #1;
      check($sformatf("lw_state_c%0d", i + 1), state_w0, step_state(nth_step(7'b0000011, i)));
      check($sformatf("lw_regwrite_c%0d", i + 1), regwrite_w0, (i == 4) ? 1 : 0);
      if (i == 4) check("lw_resultsrc_c5", resultsrc_w0, 2'b01);
    end

    // FETCH stall: three cycles without mem_ready, then one completing cycle
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op_w1 = 7'b0110011; mem_ready = 1'b0;
      #1;
      check($sformatf("stall_irwrite_c%0d", i), irwrite_w1, 1'b0);
      check($sformatf("stall_pcupdate_c%0d", i), pcupdate_w1, 1'b0);
      check($sformatf("stall_state_c%0d", i), state_w1, S_FETCH);
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    check("fetch_done_irwrite", irwrite_w1, 1'b1);
    check("fetch_done_pcupdate", pcupdate_w1, 1'b1);
    @(negedge clk); #1;
    check("after_fetch_irwrite", irwrite_w1, 1'b0);
    check("after_fetch_pcupdate", pcupdate_w1, 1'b0);
    check("after_fetch_state", state_w1, S_DECODE);

    // Reset pulse during a stalled MEMWRITE
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); op_w1 = 7'b0100011; mem_ready = 1'b1;
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    check("mw_state_before_rst", state_w1, S_MEMWRITE);
    check("mw_memwrite_before_rst", memwrite_w1, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("mw_memwrite_async_rst", memwrite_w1, 1'b0);
    check("mw_regwrite_async_rst", regwrite_w1, 1'b0);
    check("mw_state_async_rst", state_w1, S_FETCH);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); mem_ready = 1'b1; #1;
    check("mw_state_after_release", state_w1, S_FETCH);
    @(negedge clk); #1;
    check("mw_first_edge_decode", state_w1, S_DECODE);

    // Randomized run against the step-list model, both instances
    do_reset();
    exp_q1.delete(); exp_q0.delete();
    rop1 = '0; rop0 = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (exp_q1.size() == 0) begin
        rop1 = pick_op();
        for (int i = 0; i < n_steps(rop1); i++) exp_q1.push_back(nth_step(rop1, i));
      end
      if (exp_q0.size() == 0) begin
        rop0 = pick_op();
        for (int i = 0; i < n_steps(rop0); i++) exp_q0.push_back(nth_step(rop0, i));
      end
      op_w1 = rop1; op_w0 = rop0;
      mem_ready = ($urandom_range(0, 3) != 0);
      #1;
      s1 = exp_q1[0];
      s0 = exp_q0[0];
      check("rand_out_w1", act_w1, exp_out(s1, mem_ready, 1'b1, rop1));
      check("rand_state_w1", state_w1, step_state(s1));
      check("rand_out_w0", act_w0, exp_out(s0, mem_ready, 1'b0, rop0));
      check("rand_state_w0", state_w0, step_state(s0));
      if (!(is_mem(s1) && !mem_ready)) void'(exp_q1.pop_front());
      void'(exp_q0.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL have parameter WAIT_MEM, default 1, meaning: 1 makes the FETCH, MEMREAD and MEMWRITE states hold until mem_ready=1; 0 ignores mem_ready.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes happen on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port op, input, 7, the instruction opcode bits [6:0] taken from the instruction register.
REQ-005 The block SHALL have port mem_ready, input, 1, the memory access-complete strobe.
REQ-006 The block SHALL have ports pcupdate, branch, regwrite, memwrite, irwrite and adrsrc, each output, 1, the datapath enables/selects.
REQ-007 The block SHALL have ports resultsrc, alusrca, alusrcb and aluop, each output, 2: aluop 00=add, 01=sub, 10=funct-decoded.
REQ-008 The block SHALL have port illegal_op, output, 1, a one-cycle flag for an unsupported opcode.

Function
REQ-009 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, ALUWB, EXECI, JAL, BEQ; outputs are Moore (a function of state only), except that irwrite and pcupdate in FETCH are qualified by the access completing.
REQ-010 FETCH SHALL drive adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10; irwrite=1 and pcupdate=1 only in the cycle it exits (mem_ready=1 or WAIT_MEM=0); otherwise it holds.
REQ-011 DECODE SHALL drive alusrca=01, alusrcb=01, aluop=00, then branch on op: 0000011 or 0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1101111->JAL; 1100011->BEQ.
REQ-012 Any other op in DECODE SHALL assert illegal_op for that cycle and go to FETCH with no register or memory write.
REQ-013 MEMADR SHALL drive alusrca=10, alusrcb=01, aluop=00, then go to MEMREAD if op=0000011, else MEMWRITE.
REQ-014 MEMREAD SHALL drive resultsrc=00, adrsrc=1 and hold until the access completes, then go to MEMWB.
REQ-015 MEMWB SHALL drive resultsrc=01, regwrite=1 for one cycle, then go to FETCH.
REQ-016 MEMWRITE SHALL drive resultsrc=00, adrsrc=1, memwrite=1 every cycle it holds, and go to FETCH when the access completes.
REQ-017 EXECR SHALL drive alusrca=10, alusrcb=00, aluop=10; EXECI SHALL drive alusrca=10, alusrcb=01, aluop=10; both then go to ALUWB.
REQ-018 ALUWB SHALL drive resultsrc=00, regwrite=1, then go to FETCH.
REQ-019 JAL SHALL drive alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1, then go to ALUWB.
REQ-020 BEQ SHALL drive alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1, then go to FETCH.
REQ-021 Every output not listed for a state SHALL be 0; no output SHALL ever be X.
REQ-022 Instruction latencies SHALL be, with WAIT_MEM=0: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles; each memory wait adds one cycle per cycle mem_ready is low.
REQ-023 An unreachable state encoding SHALL recover to FETCH on the next edge.

Reset
REQ-024 reset=1 SHALL force state to FETCH immediately, at any point including mid-instruction or during a memory wait, with memwrite=0 and regwrite=0 from that moment.
REQ-025 After reset deasserts, the first active edge SHALL evaluate FETCH normally.

Structure
REQ-026 The state enum, opcode constants, and the aluop/alusrca/alusrcb/resultsrc encodings SHALL reside in a shared package (riscv_pkg) that alu_dec and the datapath also import.
REQ-027 The block SHALL be a single module with no sub-module; the state register and next-state/output logic are separate processes.

Verification
REQ-028 Reset pulse asserted mid-MEMWRITE -> memwrite drops to 0 asynchronously; the state is FETCH after release.
REQ-029 With WAIT_MEM=0 and op=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; regwrite=1 only in cycle 5 with resultsrc=01.
REQ-030 With WAIT_MEM=1, mem_ready held low for 3 cycles in FETCH -> irwrite=0 and pcupdate=0 for those 3 cycles, then both are 1 for exactly 1 cycle.
REQ-031 op=1100011 -> the BEQ cycle shows aluop=01, branch=1, alusrcb=00, and the next state is FETCH (3 cycles total).
REQ-032 op=1111111 -> illegal_op=1 in DECODE only, then FETCH; regwrite and memwrite stay 0 throughout.
REQ-033 op=1101111 -> JAL has pcupdate=1, alusrca=01, alusrcb=10, then ALUWB has regwrite=1.
